// File: rtl/opl3_timer_status.sv
// OPL3 interval timers (T1/T2), their overflow flags and the IRQ/status word.
// Consumes the bank-0 register-write stream; all outputs are registered.
package opl3_timer_status_pkg;
  localparam int REG_FILE_DATA_WIDTH = 8;
  localparam int REG_ADDR_WIDTH      = 8;

  typedef struct packed {
    logic                           valid;
    logic                           bank_num;
    logic [REG_ADDR_WIDTH-1:0]      address;
    logic [REG_FILE_DATA_WIDTH-1:0] data;
  } opl3_reg_wr_t;
endpackage

// One interval timer: 8-bit up-counter with preset reload and its overflow flag.
module opl3_timer_ch (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_q,
  input  logic       start_d,
  input  logic       mask_d,
  input  logic       force_ovf,
  input  logic       irq_clr,
  input  logic [7:0] preset,
  output logic       flag_d
);
  logic [7:0] cnt_q, cnt_d;
  logic       flag_q;
  logic       ovf;

  assign ovf = start_q && tick && (cnt_q == 8'hFF);

  always_comb begin
    cnt_d = cnt_q;
    if (start_d && !start_q)
      cnt_d = preset;
    else if (start_q && tick)
      cnt_d = ovf ? preset : cnt_q + 8'd1;
  end

  // Priority: IRQ-reset clear < overflow/force set < mask.
  always_comb begin
    flag_d = flag_q;
    if (irq_clr)          flag_d = 1'b0;
    if (ovf || force_ovf) flag_d = 1'b1;
    if (mask_d)           flag_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      flag_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      flag_q <= flag_d;
    end
  end
endmodule

module opl3_timer_status
  import opl3_timer_status_pkg::*;
#(
  parameter int unsigned T1_TICK_SAMPLES = 4,
  parameter int unsigned T2_TICK_SAMPLES = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           sample_clk_en,
  input  opl3_reg_wr_t                   opl3_reg_wr,
  input  logic                           force_timer_overflow,
  output logic [REG_FILE_DATA_WIDTH-1:0] status,
  output logic                           irq_n
);
  localparam int NUM_TMR = 2;
  localparam int PW      = (T2_TICK_SAMPLES > 1) ? $clog2(T2_TICK_SAMPLES) : 1;
  localparam logic [PW-1:0] T1_MASK = PW'(T1_TICK_SAMPLES - 1);
  localparam logic [PW-1:0] T2_LAST = PW'(T2_TICK_SAMPLES - 1);

  // Index 0 is T1, index 1 is T2.
  logic [NUM_TMR-1:0][7:0] preset_q, preset_d;
  logic [NUM_TMR-1:0]      start_q, start_d;
  logic [NUM_TMR-1:0]      mask_q, mask_d;
  logic [NUM_TMR-1:0]      tick, flag_d;
  logic                    irq_clr;
  logic [PW-1:0]           presc_q, presc_d;
  logic [REG_FILE_DATA_WIDTH-1:0] status_q, status_d;
  logic                    irq_n_q;
  logic                    wr_bank0;

  assign wr_bank0 = opl3_reg_wr.valid && !opl3_reg_wr.bank_num;

  always_comb begin
    preset_d = preset_q;
    start_d  = start_q;
    mask_d   = mask_q;
    irq_clr  = 1'b0;
    if (wr_bank0) begin
      case (opl3_reg_wr.address)
        8'h02: preset_d[0] = opl3_reg_wr.data;
        8'h03: preset_d[1] = opl3_reg_wr.data;
        8'h04: begin
          if (opl3_reg_wr.data[7]) begin
            irq_clr = 1'b1;
          end else begin
            mask_d[0]  = opl3_reg_wr.data[6];
            mask_d[1]  = opl3_reg_wr.data[5];
            start_d[1] = opl3_reg_wr.data[1];
            start_d[0] = opl3_reg_wr.data[0];
          end
        end
        default: ;
      endcase
    end
  end

  // Free-running prescaler; power-of-two period so natural wrap is the modulus.
  assign presc_d = sample_clk_en ? presc_q + PW'(1) : presc_q;
  assign tick[0] = sample_clk_en && ((presc_q & T1_MASK) == T1_MASK);
  assign tick[1] = sample_clk_en && (presc_q == T2_LAST);

  for (genvar g = 0; g < NUM_TMR; g++) begin : g_tmr
    opl3_timer_ch u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick[g]),
      .start_q   (start_q[g]),
      .start_d   (start_d[g]),
      .mask_d    (mask_d[g]),
      .force_ovf (force_timer_overflow),
      .irq_clr   (irq_clr),
      .preset    (preset_q[g]),
      .flag_d    (flag_d[g])
    );
  end

  assign status_d = {(|flag_d), flag_d[0], flag_d[1], {(REG_FILE_DATA_WIDTH-3){1'b0}}};

  always_ff @(posedge clk) begin
    if (reset) begin
      preset_q <= '0;
      start_q  <= '0;
      mask_q   <= '0;
      presc_q  <= '0;
      status_q <= '0;
      irq_n_q  <= 1'b1;
    end else begin
      preset_q <= preset_d;
      start_q  <= start_d;
      mask_q   <= mask_d;
      presc_q  <= presc_d;
      status_q <= status_d;
      irq_n_q  <= !(|flag_d);
    end
  end

  assign status = status_q;
  assign irq_n  = irq_n_q;
endmodule
